wb_pipe_stage: RTL and testbench
================================

Name: wb_pipe_stage

Overview:
- Parametrised MEM->WB pipeline stage register: carries LANES independent register-write channels (ctrl, addr, data) from the memory stage to the register file.
- Elastic valid/ready handshake with a 2-entry skid buffer, so upstream ready is a pure register output and no beat is lost when downstream back-pressures.
- Retains the legacy stall input. Adds synchronous flush and optional squash of writes to register 0.

Parameters:
- ADDR_W, 5, register address width per lane
- DATA_W, 32, write data width per lane
- LANES, 1, number of write-back channels (1..4)
- ZERO_SQUASH, 1, when 1 a lane write with addr==0 is captured with ctrl=0

Ports:
- clk_i  in  1  clock; everything is sampled at posedge
- rst_n_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat
- reg_write_ctrl_i  in  LANES  per-lane write enable
- reg_write_addr_i  in  LANES*ADDR_W  per-lane address; lane k at [k*ADDR_W +: ADDR_W]
- reg_write_data_i  in  LANES*DATA_W  per-lane data; lane k at [k*DATA_W +: DATA_W]
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- reg_write_ctrl_o  out  LANES  per-lane write enable, gated by valid_o
- reg_write_addr_o  out  LANES*ADDR_W  per-lane address
- reg_write_data_o  out  LANES*DATA_W  per-lane data
- occupancy_o  out  2  entries held, 0..2
- stall_ctrl_i  in  1  hold: downstream accept is forced to 0
- flush_i  in  1  synchronous discard of all held and incoming beats

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Storage: main entry (drives the outputs) and skid entry. Each entry holds a valid bit, ctrl[LANES], addr and data.
- Reset (rst_n_i=0), immediate and independent of clk:
  - all valid bits, ctrl, addr and data cleared to 0
  - valid_o=0, reg_write_ctrl_o=0, addr/data outputs 0
  - occupancy_o=0, ready_o=1
- ready_o = !skid_valid. Registered; no combinational path from ready_i.
- Input transfer: in_fire = valid_i & ready_o.
- Output transfer: out_fire = valid_o & ready_i & !stall_ctrl_i.
- Capture rule: lane k ctrl is stored as ctrl_i[k] & !(ZERO_SQUASH & addr_k==0). Addr and data are stored unmodified.
- Next-state priority, highest first:
  1. flush_i=1: both valids cleared next cycle; incoming beat dropped even if in_fire; ctrl fields cleared; addr/data don't-care.
  2. out_fire & skid_valid: skid moves to main; skid cleared.
  3. out_fire & !skid_valid: main takes the input beat if in_fire, else main becomes empty.
  4. !out_fire & main_valid & in_fire: beat goes to skid.
  5. !main_valid & in_fire: beat goes to main.
  6. Otherwise hold.
- Latency: an accepted beat appears on the outputs the next cycle when the stage is empty. Throughput is 1 beat/cycle with ready_i=1 and stall_ctrl_i=0.
- Outputs: valid_o = main_valid. reg_write_ctrl_o = main_ctrl & {LANES{main_valid}}. Addr/data show main contents, which are held (not cleared) when the entry empties.
- occupancy_o = main_valid + skid_valid.
- Beat order is strictly preserved. The skid never holds a beat while main is empty.
- Stall mid-burst:
  - 1st beat held in main, 2nd in skid; then ready_o=0.
  - On stall release, the skid beat drains the cycle after main.
- Reset mid-operation: held beats are lost. No output glitch beyond the asynchronous clear.

Test Plan:
- Reset: rst_n_i=0 with valid_i=1, ctrl=1, addr=5 -> valid_o=0, reg_write_ctrl_o=0, data_o=0, ready_o=1, occupancy_o=0. After release and one beat (addr=5, data=32'hDEADBEEF) -> valid_o=1 next cycle with those values.
- Streaming: LANES=2, ready_i=1, beats A,B,C on consecutive cycles -> outputs A,B,C on the next three cycles; occupancy_o stays 1; ready_o stays 1.
- Back-pressure/skid: stall_ctrl_i=1 while sending A,B,C -> A in main, B in skid, occupancy_o=2, ready_o=0 so C is held upstream. Release stall -> outputs A, B, C in order; no loss or duplication.
- Flush: occupancy_o=2 with flush_i=1 and valid_i=1 (beat D) -> next cycle valid_o=0, occupancy_o=0, ready_o=1, reg_write_ctrl_o=0; D never appears.
- Zero squash: ZERO_SQUASH=1, lane0 ctrl=1 addr=0, lane1 ctrl=1 addr=7 -> reg_write_ctrl_o=2'b10. With ZERO_SQUASH=0 the same beat -> 2'b11.
- Async reset while occupancy_o=2 mid-clock -> outputs clear immediately; no held beat emerges after release.

Source files
------------

// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - MEM->WB pipeline stage register with valid/ready skid buffer
module wb_pipe_stage #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int LANES       = 1,
  parameter int ZERO_SQUASH = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [LANES-1:0]          reg_write_ctrl_i,
  input  logic [LANES*ADDR_W-1:0]   reg_write_addr_i,
  input  logic [LANES*DATA_W-1:0]   reg_write_data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [LANES-1:0]          reg_write_ctrl_o,
  output logic [LANES*ADDR_W-1:0]   reg_write_addr_o,
  output logic [LANES*DATA_W-1:0]   reg_write_data_o,
  output logic [1:0]                occupancy_o,
  input  logic                      stall_ctrl_i,
  input  logic                      flush_i
);

  logic                    main_valid;
  logic [LANES-1:0]        main_ctrl;
  logic [LANES*ADDR_W-1:0] main_addr;
  logic [LANES*DATA_W-1:0] main_data;

  logic                    skid_valid;
  logic [LANES-1:0]        skid_ctrl;
  logic [LANES*ADDR_W-1:0] skid_addr;
  logic [LANES*DATA_W-1:0] skid_data;

  logic [LANES-1:0]        cap_ctrl;
  logic                    in_fire;
  logic                    out_fire;

  // Upstream ready depends only on the skid register, never on ready_i.
  assign ready_o  = !skid_valid;
  assign in_fire  = valid_i && !skid_valid;
  assign out_fire = main_valid && ready_i && !stall_ctrl_i;

  // Writes to register 0 are turned into no-ops at capture time when squashing is enabled.
  always_comb begin
    cap_ctrl = reg_write_ctrl_i;
    for (int k = 0; k < LANES; k++) begin
      if ((ZERO_SQUASH != 0) && (reg_write_addr_i[k*ADDR_W +: ADDR_W] == '0)) begin
        cap_ctrl[k] = 1'b0;
      end
    end
  end

  // Main/skid entry update: flush, then drain skid, then refill main, then park in skid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_addr  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_addr  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (out_fire && skid_valid) begin
      main_valid <= 1'b1;
      main_ctrl  <= skid_ctrl;
      main_addr  <= skid_addr;
      main_data  <= skid_data;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (out_fire) begin
      if (in_fire) begin
        main_valid <= 1'b1;
        main_ctrl  <= cap_ctrl;
        main_addr  <= reg_write_addr_i;
        main_data  <= reg_write_data_i;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire && main_valid) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= cap_ctrl;
      skid_addr  <= reg_write_addr_i;
      skid_data  <= reg_write_data_i;
    end else if (in_fire) begin
      main_valid <= 1'b1;
      main_ctrl  <= cap_ctrl;
      main_addr  <= reg_write_addr_i;
      main_data  <= reg_write_data_i;
    end
  end

  assign valid_o          = main_valid;
  assign reg_write_ctrl_o = main_ctrl & {LANES{main_valid}};
  assign reg_write_addr_o = main_addr;
  assign reg_write_data_o = main_data;
  assign occupancy_o      = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - self-checking bench for wb_pipe_stage against a FIFO reference model
module tb_wb_pipe_stage;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int L  = 2;

  typedef struct packed {
    logic [L-1:0]    ctrl;
    logic [L*AW-1:0] addr;
    logic [L*DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i, ready_i, stall, flush;
  logic [L-1:0]    ctrl_i;
  logic [L*AW-1:0] addr_i;
  logic [L*DW-1:0] data_i;

  logic            ready_a, valid_a, ready_b, valid_b;
  logic [L-1:0]    ctrl_a, ctrl_b;
  logic [L*AW-1:0] addr_a, addr_b;
  logic [L*DW-1:0] data_a, data_b;
  logic [1:0]      occ_a, occ_b;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  wb_pipe_stage #(.ADDR_W(AW), .DATA_W(DW), .LANES(L), .ZERO_SQUASH(1)) u_sq (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_a),
    .reg_write_ctrl_i(ctrl_i), .reg_write_addr_i(addr_i), .reg_write_data_i(data_i),
    .valid_o(valid_a), .ready_i(ready_i), .reg_write_ctrl_o(ctrl_a),
    .reg_write_addr_o(addr_a), .reg_write_data_o(data_a), .occupancy_o(occ_a),
    .stall_ctrl_i(stall), .flush_i(flush)
  );

  wb_pipe_stage #(.ADDR_W(AW), .DATA_W(DW), .LANES(L), .ZERO_SQUASH(0)) u_nsq (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_b),
    .reg_write_ctrl_i(ctrl_i), .reg_write_addr_i(addr_i), .reg_write_data_i(data_i),
    .valid_o(valid_b), .ready_i(ready_i), .reg_write_ctrl_o(ctrl_b),
    .reg_write_addr_o(addr_b), .reg_write_data_o(data_b), .occupancy_o(occ_b),
    .stall_ctrl_i(stall), .flush_i(flush)
  );

  // Expected enables when writes to register 0 are suppressed.
  function automatic logic [L-1:0] squashed(beat_t b);
    logic [L-1:0] s;
    for (int k = 0; k < L; k++) s[k] = b.ctrl[k] & (b.addr[k*AW +: AW] != '0);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances with the head of the model FIFO.
  task automatic check_all();
    beat_t h;
    bit    ne;
    ne = (q.size() > 0);
    h  = ne ? q[0] : '0;
    chk("ready_a", 64'(ready_a), 64'(q.size() < 2));
    chk("ready_b", 64'(ready_b), 64'(q.size() < 2));
    chk("valid_a", 64'(valid_a), 64'(ne));
    chk("valid_b", 64'(valid_b), 64'(ne));
    chk("occ_a", 64'(occ_a), 64'(q.size()));
    chk("occ_b", 64'(occ_b), 64'(q.size()));
    chk("ctrl_a", 64'(ctrl_a), ne ? 64'(squashed(h)) : 64'd0);
    chk("ctrl_b", 64'(ctrl_b), ne ? 64'(h.ctrl) : 64'd0);
    if (ne) begin
      chk("addr_a", 64'(addr_a), 64'(h.addr));
      chk("addr_b", 64'(addr_b), 64'(h.addr));
      chk("data_a", data_a, h.data);
      chk("data_b", data_b, h.data);
    end
  endtask

  task automatic drive(input beat_t b, input bit v);
    valid_i = v;
    ctrl_i  = b.ctrl;
    addr_i  = b.addr;
    data_i  = b.data;
  endtask

  // One clock: check at negedge, then advance the model across the posedge.
  task automatic cycle(output bit accepted);
    bit    in_f, out_f;
    beat_t b;
    @(negedge clk);
    check_all();
    in_f  = valid_i && (q.size() < 2);
    out_f = (q.size() > 0) && ready_i && !stall;
    b     = '{ctrl: ctrl_i, addr: addr_i, data: data_i};
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(b);
    end
    accepted = in_f && !flush;
    #1;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < L; k++) begin
      b.ctrl[k]           = 1'($urandom);
      b.addr[k*AW +: AW]  = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      b.data[k*DW +: DW]  = $urandom;
    end
    return b;
  endfunction

  // Hold valid with one beat until the stage takes it, then move to the next.
  task automatic send_seq(input beat_t seq[$], input int max_cycles);
    int idx = 0;
    bit acc;
    for (int c = 0; c < max_cycles; c++) begin
      if (idx < seq.size()) drive(seq[idx], 1'b1);
      else drive('0, 1'b0);
      cycle(acc);
      if (acc) idx++;
    end
    chk("seq_all_sent", 64'(idx), 64'(seq.size()));
  endtask

  initial begin
    beat_t b, pend;
    beat_t seq[$];
    bit    acc, have;

    rst_n = 1'b1; ready_i = 1'b1; stall = 1'b0; flush = 1'b0;
    b = '0; b.ctrl = 2'b01; b.addr = 10'd5; b.data = '0;
    drive(b, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_ctrl", 64'(ctrl_a), 64'd0);
    chk("rst_data", data_a, 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_occ", 64'(occ_a), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_hold_data", data_b, 64'd0);
    @(negedge clk);
    drive('0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat after reset: lane0 addr 5, data DEADBEEF.
    b = '0; b.ctrl = 2'b01; b.addr = 10'd5; b.data = 64'h0000_0000_DEAD_BEEF;
    drive(b, 1'b1);
    cycle(acc);
    drive('0, 1'b0);
    chk("first_valid", 64'(valid_a), 64'd1);
    chk("first_data", data_a, 64'h0000_0000_DEAD_BEEF);
    chk("first_addr", 64'(addr_a), 64'd5);
    cycle(acc);
    cycle(acc);

    // Streaming A,B,C at full rate.
    seq.delete();
    for (int i = 0; i < 3; i++) seq.push_back(rand_beat());
    send_seq(seq, 6);

    // Back-pressure: stall while offering A,B,C; C must wait upstream.
    stall = 1'b1;
    seq.delete();
    for (int i = 0; i < 3; i++) seq.push_back(rand_beat());
    drive(seq[0], 1'b1); cycle(acc);
    drive(seq[1], 1'b1); cycle(acc);
    drive(seq[2], 1'b1); cycle(acc);
    chk("bp_occ", 64'(occ_a), 64'd2);
    chk("bp_ready", 64'(ready_a), 64'd0);
    chk("bp_c_held", 64'(acc), 64'd0);
    cycle(acc);
    stall = 1'b0;
    seq.delete(0); seq.delete(0);
    send_seq(seq, 6);

    // Flush with the stage full and a new beat D offered.
    stall = 1'b1;
    drive(rand_beat(), 1'b1); cycle(acc);
    drive(rand_beat(), 1'b1); cycle(acc);
    flush = 1'b1;
    drive(rand_beat(), 1'b1); cycle(acc);
    flush = 1'b0; stall = 1'b0;
    drive('0, 1'b0);
    chk("flush_valid", 64'(valid_a), 64'd0);
    chk("flush_occ", 64'(occ_a), 64'd0);
    chk("flush_ready", 64'(ready_a), 64'd1);
    chk("flush_ctrl", 64'(ctrl_b), 64'd0);
    repeat (3) cycle(acc);

    // Zero squash: lane0 addr 0, lane1 addr 7, both enabled.
    b = '0; b.ctrl = 2'b11; b.addr = {5'd7, 5'd0}; b.data = 64'h1111_2222_3333_4444;
    drive(b, 1'b1); cycle(acc);
    drive('0, 1'b0);
    chk("zsq_on", 64'(ctrl_a), 64'h2);
    chk("zsq_off", 64'(ctrl_b), 64'h3);
    cycle(acc);

    // Asynchronous reset between clock edges while full.
    stall = 1'b1;
    drive(rand_beat(), 1'b1); cycle(acc);
    drive(rand_beat(), 1'b1); cycle(acc);
    drive('0, 1'b0);
    chk("pre_arst_occ", 64'(occ_a), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_a), 64'd0);
    chk("arst_occ", 64'(occ_b), 64'd0);
    chk("arst_ready", 64'(ready_a), 64'd1);
    chk("arst_ctrl", 64'(ctrl_a), 64'd0);
    chk("arst_data", data_a, 64'd0);
    q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (3) cycle(acc);

    // Randomized traffic with back-pressure, stall and occasional flush.
    have = 1'b0;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have && ($urandom_range(0, 3) != 0)) begin
        pend = rand_beat();
        have = 1'b1;
      end
      drive(pend, have);
      ready_i = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 29) == 0);
      cycle(acc);
      if (acc) have = 1'b0;
    end
    flush = 1'b0; stall = 1'b0; ready_i = 1'b1;
    drive('0, 1'b0);
    repeat (4) cycle(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
